bp_tlb_miss_walker: RTL
=======================

# bp_tlb_miss_walker

Hardware page-table walker sitting directly behind the TLB. Accepts one miss at a time, walks the Sv39 page table through a single-outstanding memory read port, and either writes the resulting leaf entry back into the TLB or reports a page fault. It is the only write source for the TLB fill path (`w_i`/`entry_i`).

## Interface
- `vtag_width_p`, 27: virtual page number width (3 × 9-bit VPN segments).
- `ptag_width_p`, 28: physical page number width; physical address is `ptag_width_p+12` bits.
- `levels_p`, 3: page-table depth; walk starts at level `levels_p-1`.
- `clk_i` in 1: clock.
- `reset_i` in 1: reset, synchronous, active-high.
- `flush_i` in 1: abort any walk (sfence / satp change).
- `satp_ppn_i` in `ptag_width_p`: root table PPN, sampled at miss accept.
- `miss_v_i` in 1, `miss_vtag_i` in `vtag_width_p`, `miss_ready_o` out 1: miss request, valid/ready.
- `mem_req_v_o` out 1, `mem_req_addr_o` out `ptag_width_p+12`, `mem_req_ready_i` in 1: PTE read request.
- `mem_resp_v_i` in 1, `mem_resp_data_i` in 64: PTE read response, always accepted.
- `tlb_w_v_o` out 1, `tlb_w_vtag_o` out `vtag_width_p`, `tlb_w_entry_o` out `ptag_width_p+6`: fill, entry = {ptag, d, a, u, x, w, r}.
- `fault_v_o` out 1, `fault_vtag_o` out `vtag_width_p`: page fault pulse.
- `busy_o` out 1: walker not idle.

## Operation
- States: IDLE, SEND, WAIT, FILL, FAULT, DRAIN.
- IDLE: `miss_ready_o`=1. On `miss_v_i`: latch vtag, ppn_r←`satp_ppn_i`, level_r←`levels_p-1`; go SEND.
- SEND: `mem_req_v_o`=1, addr = {ppn_r, vpn[level_r], 3'b000}. On `mem_req_ready_i` go WAIT.
- WAIT: on `mem_resp_v_i` decode PTE (V=bit0, R1, W2, X3, U4, A6, D7, PPN=[53:10]):
  - !V, or W&!R, or PPN bits above `ptag_width_p` nonzero → FAULT.
  - R|X (leaf): superpage with nonzero low PPN segments below level_r → FAULT; else FILL.
  - Pointer at level 0 → FAULT; else ppn_r←PPN, level_r−1, SEND.
- FILL: `tlb_w_v_o`=1 for one cycle. ptag = PPN upper segments above level_r concatenated with vtag lower segments (superpage expansion). Next IDLE.
- FAULT: `fault_v_o`=1 one cycle, `fault_vtag_o`=latched vtag. Next IDLE.
- Flush: in SEND/FILL/FAULT → IDLE, no pulse emitted. In WAIT without same-cycle response → DRAIN; DRAIN discards the next `mem_resp_v_i`, then IDLE. Flush in WAIT coinciding with a response → IDLE, response dropped. Flush in IDLE blocks accept that cycle (`miss_ready_o`=0).
- `busy_o` = state≠IDLE.

## Timing
- Reset: state IDLE; `miss_ready_o`=1, all other outputs 0 (vtag/entry/addr outputs 0). Reset mid-walk returns to IDLE without drain.
- Miss accepted in cycle t → `mem_req_v_o` in t+1.
- Response in cycle r → next SEND, FILL or FAULT in r+1.
- Best-case 3-level walk with zero-latency memory: fill at accept+7.
- `mem_req_addr_o` stable while `mem_req_v_o` high and not ready.
- Responses arriving outside WAIT/DRAIN are illegal; assert in simulation.

## Configuration
- `BP_PTW_AD_FAULT_EN`: defined → a leaf with A=0 goes to FAULT (software-managed A/D). Undefined → A/D copied into the entry unchecked; enforcement happens downstream.

## Structure
- `bp_common_pkg`: walker state enum, Sv39 PTE struct, page-offset and VPN-segment width constants.
- One combinational sub-module, `bp_ptw_pte_check`: PTE in + level → {leaf, fault, ptag}.

## Test plan
- satp_ppn=0x100, vtag=0x0_0000_1 (Sv39 segments 0,0,1), three pointer/leaf PTEs with PPN=0x2345, R=W=A=D=1 → reads at 0x100000, child, grandchild; `tlb_w_entry_o` ptag=0x2345, `tlb_w_v_o` one cycle.
- Level-1 leaf PPN=0x400 (low segment 0), vtag low segment 0x1F → 2 MiB superpage, ptag=0x41F.
- Level-1 leaf PPN=0x401 → misaligned superpage; `fault_v_o` pulse, no fill.
- Root PTE V=0 → fault after one read; `miss_ready_o` high next cycle.
- Flush in WAIT, response 5 cycles later → response discarded, no fill/fault, new miss accepted only after drain.
- `BP_PTW_AD_FAULT_EN` defined, leaf A=0 → fault; undefined → fill with a=0.

Source files
------------

// File: rtl/bp_common_pkg.sv
// Shared walker types: FSM state encoding, Sv39 PTE layout and address-field widths.
// Used by the TLB miss walker; see bp_ptw_pte_check for the BP_PTW_AD_FAULT_EN option.
package bp_common_pkg;

   localparam int page_offset_width_gp = 12;
   localparam int vpn_seg_width_gp     = 9;
   localparam int pte_ppn_width_gp     = 44;

   typedef enum logic [2:0] {
      IDLE,
      SEND,
      WAIT,
      FILL,
      FAULT,
      DRAIN
   } ptw_state_e;

   typedef struct packed {
      logic [9:0]                  reserved;
      logic [pte_ppn_width_gp-1:0] ppn;
      logic [1:0]                  rsw;
      logic                        d;
      logic                        a;
      logic                        g;
      logic                        u;
      logic                        x;
      logic                        w;
      logic                        r;
      logic                        v;
   } sv39_pte_s;

endpackage

// File: rtl/bp_ptw_pte_check.sv
// Combinational Sv39 PTE decode: leaf/fault classification and superpage ptag expansion.
// Define BP_PTW_AD_FAULT_EN to fault on leaves with A=0 (software-managed A/D bits).
module bp_ptw_pte_check
   import bp_common_pkg::*;
#(
   parameter int vtag_width_p = 27,
   parameter int ptag_width_p = 28,
   parameter int levels_p     = 3,
   localparam int lvl_width_lp = $clog2(levels_p)
)
(
   input  logic [63:0]             pte,
   input  logic [lvl_width_lp-1:0] level,
   input  logic [vtag_width_p-1:0] vtag,
   output logic                    leaf,
   output logic                    fault,
   output logic [ptag_width_p-1:0] ptag,
   output logic [5:0]              perms
);

   sv39_pte_s               pte_s;
   logic [ptag_width_p-1:0] low_mask;
   logic [ptag_width_p-1:0] ppn_trunc;
   logic [ptag_width_p-1:0] vtag_ext;
   logic                    ppn_overflow;
   logic                    misaligned;
   logic                    ad_fault;
   logic                    unused_pte;

   assign pte_s      = pte;
   assign unused_pte = ^{pte_s.reserved, pte_s.rsw, pte_s.g};
   assign ppn_trunc  = pte_s.ppn[ptag_width_p-1:0];
   assign vtag_ext   = ptag_width_p'(vtag);
   assign perms      = {pte_s.d, pte_s.a, pte_s.u, pte_s.x, pte_s.w, pte_s.r};

   // VPN segments below the current level come from the virtual address on a superpage leaf
   always_comb begin
      low_mask = '0;
      for (int i = 0; i < levels_p - 1; i++) begin
         if (i < int'(level)) begin
            low_mask[i*vpn_seg_width_gp +: vpn_seg_width_gp] = '1;
         end
      end
   end

   always_comb begin
      leaf         = pte_s.v & (pte_s.r | pte_s.x);
      ppn_overflow = |pte_s.ppn[pte_ppn_width_gp-1:ptag_width_p];
      misaligned   = leaf & (|(ppn_trunc & low_mask));
`ifdef BP_PTW_AD_FAULT_EN
      ad_fault     = leaf & ~pte_s.a;
`else
      ad_fault     = 1'b0;
`endif
      fault = ~pte_s.v | (pte_s.w & ~pte_s.r) | ppn_overflow | misaligned | ad_fault
            | (~leaf & (level == '0));
      ptag  = leaf ? ((ppn_trunc & ~low_mask) | (vtag_ext & low_mask)) : ppn_trunc;
   end

endmodule

// File: rtl/bp_tlb_miss_walker.sv
// Sv39 hardware page-table walker behind the TLB: one miss at a time, one outstanding PTE read.
// Leaf A-bit enforcement is selected by BP_PTW_AD_FAULT_EN (see bp_ptw_pte_check).
module bp_tlb_miss_walker
   import bp_common_pkg::*;
#(
   parameter int vtag_width_p = 27,
   parameter int ptag_width_p = 28,
   parameter int levels_p     = 3,
   localparam int lvl_width_lp   = $clog2(levels_p),
   localparam int paddr_width_lp = ptag_width_p + page_offset_width_gp
)
(
   input  logic                      clk_i,
   input  logic                      reset_i,
   input  logic                      flush_i,
   input  logic [ptag_width_p-1:0]   satp_ppn_i,
   input  logic                      miss_v_i,
   input  logic [vtag_width_p-1:0]   miss_vtag_i,
   output logic                      miss_ready_o,
   output logic                      mem_req_v_o,
   output logic [paddr_width_lp-1:0] mem_req_addr_o,
   input  logic                      mem_req_ready_i,
   input  logic                      mem_resp_v_i,
   input  logic [63:0]               mem_resp_data_i,
   output logic                      tlb_w_v_o,
   output logic [vtag_width_p-1:0]   tlb_w_vtag_o,
   output logic [ptag_width_p+5:0]   tlb_w_entry_o,
   output logic                      fault_v_o,
   output logic [vtag_width_p-1:0]   fault_vtag_o,
   output logic                      busy_o
);

   ptw_state_e                  state_r, state_n;
   logic [vtag_width_p-1:0]     vtag_r;
   logic [ptag_width_p-1:0]     ppn_r;
   logic [lvl_width_lp-1:0]     level_r;
   logic [ptag_width_p+5:0]     entry_r;
   logic [vpn_seg_width_gp-1:0] vpn_seg;
   logic                        chk_leaf, chk_fault;
   logic [ptag_width_p-1:0]     chk_ptag;
   logic [5:0]                  chk_perms;

   bp_ptw_pte_check #(
      .vtag_width_p(vtag_width_p),
      .ptag_width_p(ptag_width_p),
      .levels_p    (levels_p)
   ) pte_check (
      .pte  (mem_resp_data_i),
      .level(level_r),
      .vtag (vtag_r),
      .leaf (chk_leaf),
      .fault(chk_fault),
      .ptag (chk_ptag),
      .perms(chk_perms)
   );

   assign vpn_seg        = vpn_seg_width_gp'(vtag_r >> (level_r * vpn_seg_width_gp));
   assign busy_o         = (state_r != IDLE);
   assign mem_req_addr_o = (state_r == SEND) ? {ppn_r, vpn_seg, 3'b000} : '0;
   assign tlb_w_vtag_o   = (state_r == FILL) ? vtag_r : '0;
   assign tlb_w_entry_o  = (state_r == FILL) ? entry_r : '0;
   assign fault_vtag_o   = (state_r == FAULT) ? vtag_r : '0;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_r <= IDLE;
         vtag_r  <= '0;
         ppn_r   <= '0;
         level_r <= '0;
         entry_r <= '0;
      end else begin
         state_r <= state_n;
         if (state_r == IDLE && miss_ready_o && miss_v_i) begin
            vtag_r  <= miss_vtag_i;
            ppn_r   <= satp_ppn_i;
            level_r <= lvl_width_lp'(levels_p - 1);
         end
         if (state_r == WAIT && mem_resp_v_i) begin
            ppn_r   <= chk_ptag;
            level_r <= level_r - lvl_width_lp'(1);
            entry_r <= {chk_ptag, chk_perms};
         end
      end
   end

   // A request is withheld under flush so no response can land after we return to IDLE
   always_comb begin
      state_n      = state_r;
      miss_ready_o = 1'b0;
      mem_req_v_o  = 1'b0;
      tlb_w_v_o    = 1'b0;
      fault_v_o    = 1'b0;
      case (state_r)
         IDLE: begin
            miss_ready_o = ~flush_i;
            if (miss_v_i && !flush_i) state_n = SEND;
         end
         SEND: begin
            if (flush_i) begin
               state_n = IDLE;
            end else begin
               mem_req_v_o = 1'b1;
               if (mem_req_ready_i) state_n = WAIT;
            end
         end
         WAIT: begin
            if (mem_resp_v_i) begin
               if (flush_i)        state_n = IDLE;
               else if (chk_fault) state_n = FAULT;
               else if (chk_leaf)  state_n = FILL;
               else                state_n = SEND;
            end else if (flush_i) begin
               state_n = DRAIN;
            end
         end
         FILL: begin
            tlb_w_v_o = ~flush_i;
            state_n   = IDLE;
         end
         FAULT: begin
            fault_v_o = ~flush_i;
            state_n   = IDLE;
         end
         DRAIN: begin
            if (mem_resp_v_i) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   resp_legal_a: assert property (@(posedge clk_i) disable iff (reset_i)
      mem_resp_v_i |-> (state_r == WAIT || state_r == DRAIN));

endmodule
